pipe_stage_reg: RTL and testbench

//  Generic parametrised pipeline-stage register for the pipelined CPU.

---
 rtl/pipe_stage_reg.sv | 63 ++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline-stage register with ready/valid stall, optional 2-entry skid buffer and flush-to-bubble
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  logic              skid_valid, rdy_q, accept, consume, adv;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  assign in_ready  = SKID_EN ? rdy_q : (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign adv       = consume | ~out_valid;
  assign occupancy = {skid_valid, out_valid & ~skid_valid};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= BUBBLE_CTRL;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      rdy_q      <= 1'b1;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= BUBBLE_CTRL;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
    end else if (adv) begin
      out_valid  <= skid_valid | accept;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
      if (skid_valid) begin
        out_data <= skid_data;
        out_ctrl <= skid_ctrl;
      end else if (accept) begin
        out_data <= in_data;
        out_ctrl <= in_ctrl;
      end else begin
        out_ctrl <= BUBBLE_CTRL;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_ctrl  <= in_ctrl;
      skid_valid <= 1'b1;
      rdy_q      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for skid and non-skid pipe_stage_reg instances
module tb_pipe_stage_reg;
  localparam logic [15:0] BUB = 16'h00B0;
  logic clk = 1'b0, reset = 1'b0;
  logic a_flush = 1'b0, a_iv = 1'b0, a_ir, a_ov, a_ordy = 1'b0;
  logic [31:0] a_id = '0, a_od;
  logic [15:0] a_ic = '0, a_oc;
  logic [1:0] a_occ;
  logic b_flush = 1'b0, b_iv = 1'b0, b_ir, b_ov, b_ordy = 1'b0;
  logic [31:0] b_id = '0, b_od;
  logic [15:0] b_ic = '0, b_oc;
  logic [1:0] b_occ;
  logic [31:0] a_q[$], b_q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .BUBBLE_CTRL(BUB), .SKID_EN(1'b1)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .in_ctrl(a_ic), .out_valid(a_ov), .out_ready(a_ordy),
    .out_data(a_od), .out_ctrl(a_oc), .occupancy(a_occ));
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .BUBBLE_CTRL(BUB), .SKID_EN(1'b0)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .in_ctrl(b_ic), .out_valid(b_ov), .out_ready(b_ordy),
    .out_data(b_od), .out_ctrl(b_oc), .occupancy(b_occ));
  function automatic logic [15:0] cf(input logic [31:0] d);
    return d[15:0] ^ 16'h5A5A;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic a_put(input logic [31:0] d);
    a_iv = 1'b1;
    a_id = d;
    a_ic = cf(d);
    a_q.push_back(d);
  endtask
  task automatic b_put(input logic [31:0] d);
    b_iv = 1'b1;
    b_id = d;
    b_ic = cf(d);
    b_q.push_back(d);
  endtask
  task automatic a_wait_acc();
    int n = 0;
    bit acc = 1'b0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = a_iv && a_ir;
      tick();
      n++;
    end
    chk("a_accept_timeout", {31'd0, acc}, 32'd1);
    a_iv = 1'b0;
  endtask
  always @(negedge clk) begin
    if (a_ov && a_ordy) begin
      if (a_q.size() == 0) chk("a_unexpected_out", a_od, 32'hFFFF_FFFF);
      else begin
        logic [31:0] e;
        e = a_q.pop_front();
        chk("a_out_data", a_od, e);
        chk("a_out_ctrl", {16'd0, a_oc}, {16'd0, cf(e)});
      end
    end
    if (!a_ov) chk("a_bubble_ctrl", {16'd0, a_oc}, {16'd0, BUB});
  end
  always @(negedge clk) begin
    if (b_ov && b_ordy) begin
      if (b_q.size() == 0) chk("b_unexpected_out", b_od, 32'hFFFF_FFFF);
      else begin
        logic [31:0] e;
        e = b_q.pop_front();
        chk("b_out_data", b_od, e);
        chk("b_out_ctrl", {16'd0, b_oc}, {16'd0, cf(e)});
      end
    end
    if (!b_ov) chk("b_bubble_ctrl", {16'd0, b_oc}, {16'd0, BUB});
  end
  initial begin
    a_iv = 1'b1;
    a_id = 32'h99;
    a_ic = cf(32'h99);
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, a_ov}, 32'd0);
    chk("rst_out_ctrl", {16'd0, a_oc}, {16'd0, BUB});
    chk("rst_occupancy", {30'd0, a_occ}, 32'd0);
    a_iv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, a_ir}, 32'd1);
    tick();
    a_ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_put(32'h100 + i);
      tick();
      chk("stream_valid", {31'd0, a_ov}, 32'd1);
      chk("stream_lat", a_od, 32'h100 + i);
      chk("stream_occ", {30'd0, a_occ}, 32'd1);
    end
    a_iv = 1'b0;
    tick();
    chk("stream_drain", {31'd0, a_ov}, 32'd0);
    a_ordy = 1'b0;
    a_put(32'hA);
    tick();
    chk("skid_occ1", {30'd0, a_occ}, 32'd1);
    chk("skid_rdy1", {31'd0, a_ir}, 32'd1);
    a_put(32'hB);
    tick();
    chk("skid_occ2", {30'd0, a_occ}, 32'd2);
    chk("skid_rdy0", {31'd0, a_ir}, 32'd0);
    a_put(32'hC);
    tick();
    tick();
    chk("skid_hold_occ", {30'd0, a_occ}, 32'd2);
    chk("skid_hold_rdy", {31'd0, a_ir}, 32'd0);
    chk("skid_hold_head", a_od, 32'hA);
    a_ordy = 1'b1;
    a_wait_acc();
    chk("skid_last_head", a_od, 32'hC);
    chk("skid_last_occ", {30'd0, a_occ}, 32'd1);
    tick();
    chk("skid_empty", {30'd0, a_occ}, 32'd0);
    a_ordy = 1'b0;
    a_put(32'h20);
    tick();
    a_put(32'h21);
    tick();
    chk("flush_pre_occ", {30'd0, a_occ}, 32'd2);
    a_put(32'h22);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    a_iv = 1'b0;
    a_q.delete();
    chk("flush_valid", {31'd0, a_ov}, 32'd0);
    chk("flush_occ", {30'd0, a_occ}, 32'd0);
    chk("flush_rdy", {31'd0, a_ir}, 32'd1);
    chk("flush_ctrl", {16'd0, a_oc}, {16'd0, BUB});
    a_flush = 1'b1;
    tick();
    tick();
    a_flush = 1'b0;
    chk("flush_hold_occ", {30'd0, a_occ}, 32'd0);
    a_ordy = 1'b1;
    tick();
    tick();
    chk("flush_no_emit", {31'd0, a_ov}, 32'd0);
    a_ordy = 1'b0;
    a_put(32'h30);
    tick();
    a_put(32'h31);
    tick();
    a_iv = 1'b0;
    chk("arst_pre_occ", {30'd0, a_occ}, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    a_q.delete();
    chk("arst_valid", {31'd0, a_ov}, 32'd0);
    chk("arst_occ", {30'd0, a_occ}, 32'd0);
    chk("arst_ctrl", {16'd0, a_oc}, {16'd0, BUB});
    chk("arst_rdy", {31'd0, a_ir}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    a_put(32'h40);
    a_ordy = 1'b1;
    tick();
    a_iv = 1'b0;
    chk("arst_post_valid", {31'd0, a_ov}, 32'd1);
    chk("arst_post_data", a_od, 32'h40);
    tick();
    a_ordy = 1'b0;
    b_ordy = 1'b0;
    b_put(32'h50);
    tick();
    b_iv = 1'b0;
    chk("b_valid", {31'd0, b_ov}, 32'd1);
    chk("b_occ1", {30'd0, b_occ}, 32'd1);
    chk("b_rdy_stall", {31'd0, b_ir}, 32'd0);
    b_ordy = 1'b1;
    #1;
    chk("b_rdy_comb", {31'd0, b_ir}, 32'd1);
    b_put(32'h51);
    tick();
    b_iv = 1'b0;
    chk("b_replace_data", b_od, 32'h51);
    chk("b_replace_occ", {30'd0, b_occ}, 32'd1);
    tick();
    chk("b_drain_occ", {30'd0, b_occ}, 32'd0);
    chk("b_empty_rdy", {31'd0, b_ir}, 32'd1);
    tick();
    chk("a_queue_left", a_q.size(), 32'd0);
    chk("b_queue_left", b_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
